// File: rtl/ifq_pkg.sv
// Shared types and defaults for the instruction-fetch queue.
package ifq_pkg;

    typedef enum logic {FETCH = 1'b0, DRAIN = 1'b1} ifq_state_t;

    localparam int unsigned IFQ_DEFAULT_DEPTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ifq_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// Generic synchronous FIFO; push while full is accepted only alongside a pop.
module ifq_fifo
    import ifq_pkg::*;
#(
    parameter int unsigned DEPTH = IFQ_DEFAULT_DEPTH,
    parameter int unsigned WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);
    localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign empty     = (count_r == {CW{1'b0}});
    assign full      = (count_r == CW'(DEPTH));
    assign count     = count_r;
    assign head_data = mem_r[rd_ptr_r];
    assign pop_ok_s  = pop && !empty;
    assign push_ok_s = push && (!full || pop_ok_s);

    // Pointers and occupancy; clear empties the FIFO without touching storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (clear) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
            if (push_ok_s && !pop_ok_s)      count_r <= count_r + CNT_ONE;
            else if (pop_ok_s && !push_ok_s) count_r <= count_r - CNT_ONE;
            else                             count_r <= count_r;
        end
    end

    // Storage array, zeroed at reset so the head reads 0 before any push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_r[i] <= {WIDTH{1'b0}};
        end else if (push_ok_s && !clear) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: credit-limited sequential fetch, in-order tag matching, flush/drain.
// Optional macro IFQ_BYPASS_EN: forward a response straight to decode when the queue is empty.
module ifetch_queue
    import ifq_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = IFQ_DEFAULT_DEPTH,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned     PC_STEP  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic                        imem_req_valid,
    input  logic                        imem_req_ready,
    output logic [XLEN-1:0]             imem_req_addr,
    input  logic                        imem_rsp_valid,
    input  logic [XLEN-1:0]             imem_rsp_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [XLEN-1:0]             out_instr,
    output logic [XLEN-1:0]             out_pc,
    input  logic                        flush,
    input  logic [XLEN-1:0]             flush_pc,
    output logic [$clog2(DEPTH+1)-1:0]  count
);
    localparam int unsigned   CW      = $clog2(DEPTH+1);
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW:0]   CREDITS = (CW+1)'(DEPTH);

    ifq_state_t      state_r;
    logic [XLEN-1:0] fetch_pc_r;
    logic [CW-1:0]   outstanding_r;
    logic [CW-1:0]   discard_r;
    logic [CW-1:0]   outstanding_nx_s;
    logic [CW-1:0]   q_count_s;
    logic [CW-1:0]   tag_count_s;
    logic [XLEN-1:0] tag_head_s;
    ifq_entry_t      q_head_s;
    ifq_entry_t      q_push_data_s;
    logic            q_empty_s, q_full_s, tag_empty_s, tag_full_s;
    logic            accept_s, rsp_s, keep_s, q_push_s, q_pop_s;

    // Credits cover both queued entries and requests still in flight.
    assign imem_req_valid = rst && (state_r == FETCH) && !flush &&
                            (({1'b0, q_count_s} + {1'b0, outstanding_r}) < CREDITS);
    assign imem_req_addr  = fetch_pc_r;
    assign accept_s       = imem_req_valid && imem_req_ready;
    // Responses with nothing outstanding are leftovers from before a reset.
    assign rsp_s          = imem_rsp_valid && (outstanding_r != {CW{1'b0}});
    assign keep_s         = rsp_s && (discard_r == {CW{1'b0}}) && !flush;
    assign count          = q_count_s;

    assign q_push_data_s.pc    = tag_head_s;
    assign q_push_data_s.instr = imem_rsp_data;

`ifdef IFQ_BYPASS_EN
    logic byp_s;
    assign byp_s     = keep_s && q_empty_s;
    assign out_valid = !q_empty_s || byp_s;
    assign out_instr = q_empty_s ? imem_rsp_data : q_head_s.instr;
    assign out_pc    = q_empty_s ? tag_head_s    : q_head_s.pc;
    assign q_push_s  = keep_s && !(byp_s && out_ready);
    assign q_pop_s   = out_ready && !q_empty_s;
`else
    assign out_valid = !q_empty_s;
    assign out_instr = q_head_s.instr;
    assign out_pc    = q_head_s.pc;
    assign q_push_s  = keep_s;
    assign q_pop_s   = out_valid && out_ready;
`endif

    // Next in-flight request count from this cycle's accept and response.
    always_comb begin
        outstanding_nx_s = outstanding_r;
        if (accept_s && !rsp_s) begin
            outstanding_nx_s = outstanding_r + CNT_ONE;
        end else if (rsp_s && !accept_s) begin
            outstanding_nx_s = outstanding_r - CNT_ONE;
        end else begin
            outstanding_nx_s = outstanding_r;
        end
    end

    // Fetch PC, credit tracking and the FETCH/DRAIN controller.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= FETCH;
            fetch_pc_r    <= RESET_PC;
            outstanding_r <= {CW{1'b0}};
            discard_r     <= {CW{1'b0}};
        end else if (flush) begin
            fetch_pc_r    <= flush_pc;
            outstanding_r <= outstanding_nx_s;
            discard_r     <= outstanding_nx_s;
            state_r       <= (outstanding_nx_s != {CW{1'b0}}) ? DRAIN : FETCH;
        end else begin
            outstanding_r <= outstanding_nx_s;
            if (accept_s) fetch_pc_r <= fetch_pc_r + XLEN'(PC_STEP);
            case (state_r)
                FETCH: state_r <= FETCH;
                DRAIN: begin
                    if (rsp_s) begin
                        discard_r <= discard_r - CNT_ONE;
                        if (discard_r == CNT_ONE) state_r <= FETCH;
                    end
                end
                default: state_r <= FETCH;
            endcase
        end
    end

    ifq_fifo #(.DEPTH(DEPTH), .WIDTH(XLEN)) u_tag_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .clear     (flush),
        .push      (accept_s),
        .push_data (fetch_pc_r),
        .pop       (keep_s),
        .head_data (tag_head_s),
        .full      (tag_full_s),
        .empty     (tag_empty_s),
        .count     (tag_count_s)
    );

    ifq_fifo #(.DEPTH(DEPTH), .WIDTH($bits(ifq_entry_t))) u_instr_q (
        .clk       (clk),
        .rst_n     (rst),
        .clear     (flush),
        .push      (q_push_s),
        .push_data (q_push_data_s),
        .pop       (q_pop_s),
        .head_data (q_head_s),
        .full      (q_full_s),
        .empty     (q_empty_s),
        .count     (q_count_s)
    );

endmodule
